// File: rtl/data_memory.sv
// data_memory: 256 x 32-bit MEM-stage data memory, synchronous write, combinational read,
// every word mirrored on its own debug port.
module data_memory (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MR,
    input  logic        MW,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic [31:0] memOut0, memOut1, memOut2, memOut3, memOut4, memOut5, memOut6, memOut7,
    output logic [31:0] memOut8, memOut9, memOut10, memOut11, memOut12, memOut13, memOut14, memOut15,
    output logic [31:0] memOut16, memOut17, memOut18, memOut19, memOut20, memOut21, memOut22, memOut23,
    output logic [31:0] memOut24, memOut25, memOut26, memOut27, memOut28, memOut29, memOut30, memOut31,
    output logic [31:0] memOut32, memOut33, memOut34, memOut35, memOut36, memOut37, memOut38, memOut39,
    output logic [31:0] memOut40, memOut41, memOut42, memOut43, memOut44, memOut45, memOut46, memOut47,
    output logic [31:0] memOut48, memOut49, memOut50, memOut51, memOut52, memOut53, memOut54, memOut55,
    output logic [31:0] memOut56, memOut57, memOut58, memOut59, memOut60, memOut61, memOut62, memOut63,
    output logic [31:0] memOut64, memOut65, memOut66, memOut67, memOut68, memOut69, memOut70, memOut71,
    output logic [31:0] memOut72, memOut73, memOut74, memOut75, memOut76, memOut77, memOut78, memOut79,
    output logic [31:0] memOut80, memOut81, memOut82, memOut83, memOut84, memOut85, memOut86, memOut87,
    output logic [31:0] memOut88, memOut89, memOut90, memOut91, memOut92, memOut93, memOut94, memOut95,
    output logic [31:0] memOut96, memOut97, memOut98, memOut99, memOut100, memOut101, memOut102, memOut103,
    output logic [31:0] memOut104, memOut105, memOut106, memOut107, memOut108, memOut109, memOut110, memOut111,
    output logic [31:0] memOut112, memOut113, memOut114, memOut115, memOut116, memOut117, memOut118, memOut119,
    output logic [31:0] memOut120, memOut121, memOut122, memOut123, memOut124, memOut125, memOut126, memOut127,
    output logic [31:0] memOut128, memOut129, memOut130, memOut131, memOut132, memOut133, memOut134, memOut135,
    output logic [31:0] memOut136, memOut137, memOut138, memOut139, memOut140, memOut141, memOut142, memOut143,
    output logic [31:0] memOut144, memOut145, memOut146, memOut147, memOut148, memOut149, memOut150, memOut151,
    output logic [31:0] memOut152, memOut153, memOut154, memOut155, memOut156, memOut157, memOut158, memOut159,
    output logic [31:0] memOut160, memOut161, memOut162, memOut163, memOut164, memOut165, memOut166, memOut167,
    output logic [31:0] memOut168, memOut169, memOut170, memOut171, memOut172, memOut173, memOut174, memOut175,
    output logic [31:0] memOut176, memOut177, memOut178, memOut179, memOut180, memOut181, memOut182, memOut183,
    output logic [31:0] memOut184, memOut185, memOut186, memOut187, memOut188, memOut189, memOut190, memOut191,
    output logic [31:0] memOut192, memOut193, memOut194, memOut195, memOut196, memOut197, memOut198, memOut199,
    output logic [31:0] memOut200, memOut201, memOut202, memOut203, memOut204, memOut205, memOut206, memOut207,
    output logic [31:0] memOut208, memOut209, memOut210, memOut211, memOut212, memOut213, memOut214, memOut215,
    output logic [31:0] memOut216, memOut217, memOut218, memOut219, memOut220, memOut221, memOut222, memOut223,
    output logic [31:0] memOut224, memOut225, memOut226, memOut227, memOut228, memOut229, memOut230, memOut231,
    output logic [31:0] memOut232, memOut233, memOut234, memOut235, memOut236, memOut237, memOut238, memOut239,
    output logic [31:0] memOut240, memOut241, memOut242, memOut243, memOut244, memOut245, memOut246, memOut247,
    output logic [31:0] memOut248, memOut249, memOut250, memOut251, memOut252, memOut253, memOut254, memOut255
);
    // Power-up value is all zeros so an unreset simulation never shows X.
    logic [31:0] r_mem [256] = '{default: '0};
    logic [7:0]  w_idx;
    logic        w_unused;
    assign w_idx    = Addr[9:2];
    assign w_unused = ^{Addr[31:10], Addr[1:0]};
    always_ff @(posedge Clk) begin
        if (Rst) r_mem <= '{default: '0};
        else if (MW) r_mem[w_idx] <= WD;
    end
    // No write bypass: RD shows the stored word until the edge commits WD.
    assign RD = MR ? r_mem[w_idx] : '0;
    assign memOut0 = r_mem[0]; assign memOut1 = r_mem[1]; assign memOut2 = r_mem[2]; assign memOut3 = r_mem[3];
    assign memOut4 = r_mem[4]; assign memOut5 = r_mem[5]; assign memOut6 = r_mem[6]; assign memOut7 = r_mem[7];
    assign memOut8 = r_mem[8]; assign memOut9 = r_mem[9]; assign memOut10 = r_mem[10]; assign memOut11 = r_mem[11];
    assign memOut12 = r_mem[12]; assign memOut13 = r_mem[13]; assign memOut14 = r_mem[14]; assign memOut15 = r_mem[15];
    assign memOut16 = r_mem[16]; assign memOut17 = r_mem[17]; assign memOut18 = r_mem[18]; assign memOut19 = r_mem[19];
    assign memOut20 = r_mem[20]; assign memOut21 = r_mem[21]; assign memOut22 = r_mem[22]; assign memOut23 = r_mem[23];
    assign memOut24 = r_mem[24]; assign memOut25 = r_mem[25]; assign memOut26 = r_mem[26]; assign memOut27 = r_mem[27];
    assign memOut28 = r_mem[28]; assign memOut29 = r_mem[29]; assign memOut30 = r_mem[30]; assign memOut31 = r_mem[31];
    assign memOut32 = r_mem[32]; assign memOut33 = r_mem[33]; assign memOut34 = r_mem[34]; assign memOut35 = r_mem[35];
    assign memOut36 = r_mem[36]; assign memOut37 = r_mem[37]; assign memOut38 = r_mem[38]; assign memOut39 = r_mem[39];
    assign memOut40 = r_mem[40]; assign memOut41 = r_mem[41]; assign memOut42 = r_mem[42]; assign memOut43 = r_mem[43];
    assign memOut44 = r_mem[44]; assign memOut45 = r_mem[45]; assign memOut46 = r_mem[46]; assign memOut47 = r_mem[47];
    assign memOut48 = r_mem[48]; assign memOut49 = r_mem[49]; assign memOut50 = r_mem[50]; assign memOut51 = r_mem[51];
    assign memOut52 = r_mem[52]; assign memOut53 = r_mem[53]; assign memOut54 = r_mem[54]; assign memOut55 = r_mem[55];
    assign memOut56 = r_mem[56]; assign memOut57 = r_mem[57]; assign memOut58 = r_mem[58]; assign memOut59 = r_mem[59];
    assign memOut60 = r_mem[60]; assign memOut61 = r_mem[61]; assign memOut62 = r_mem[62]; assign memOut63 = r_mem[63];
    assign memOut64 = r_mem[64]; assign memOut65 = r_mem[65]; assign memOut66 = r_mem[66]; assign memOut67 = r_mem[67];
    assign memOut68 = r_mem[68]; assign memOut69 = r_mem[69]; assign memOut70 = r_mem[70]; assign memOut71 = r_mem[71];
    assign memOut72 = r_mem[72]; assign memOut73 = r_mem[73]; assign memOut74 = r_mem[74]; assign memOut75 = r_mem[75];
    assign memOut76 = r_mem[76]; assign memOut77 = r_mem[77]; assign memOut78 = r_mem[78]; assign memOut79 = r_mem[79];
    assign memOut80 = r_mem[80]; assign memOut81 = r_mem[81]; assign memOut82 = r_mem[82]; assign memOut83 = r_mem[83];
    assign memOut84 = r_mem[84]; assign memOut85 = r_mem[85]; assign memOut86 = r_mem[86]; assign memOut87 = r_mem[87];
    assign memOut88 = r_mem[88]; assign memOut89 = r_mem[89]; assign memOut90 = r_mem[90]; assign memOut91 = r_mem[91];
    assign memOut92 = r_mem[92]; assign memOut93 = r_mem[93]; assign memOut94 = r_mem[94]; assign memOut95 = r_mem[95];
    assign memOut96 = r_mem[96]; assign memOut97 = r_mem[97]; assign memOut98 = r_mem[98]; assign memOut99 = r_mem[99];
    assign memOut100 = r_mem[100]; assign memOut101 = r_mem[101]; assign memOut102 = r_mem[102]; assign memOut103 = r_mem[103];
    assign memOut104 = r_mem[104]; assign memOut105 = r_mem[105]; assign memOut106 = r_mem[106]; assign memOut107 = r_mem[107];
    assign memOut108 = r_mem[108]; assign memOut109 = r_mem[109]; assign memOut110 = r_mem[110]; assign memOut111 = r_mem[111];
    assign memOut112 = r_mem[112]; assign memOut113 = r_mem[113]; assign memOut114 = r_mem[114]; assign memOut115 = r_mem[115];
    assign memOut116 = r_mem[116]; assign memOut117 = r_mem[117]; assign memOut118 = r_mem[118]; assign memOut119 = r_mem[119];
    assign memOut120 = r_mem[120]; assign memOut121 = r_mem[121]; assign memOut122 = r_mem[122]; assign memOut123 = r_mem[123];
    assign memOut124 = r_mem[124]; assign memOut125 = r_mem[125]; assign memOut126 = r_mem[126]; assign memOut127 = r_mem[127];
    assign memOut128 = r_mem[128]; assign memOut129 = r_mem[129]; assign memOut130 = r_mem[130]; assign memOut131 = r_mem[131];
    assign memOut132 = r_mem[132]; assign memOut133 = r_mem[133]; assign memOut134 = r_mem[134]; assign memOut135 = r_mem[135];
    assign memOut136 = r_mem[136]; assign memOut137 = r_mem[137]; assign memOut138 = r_mem[138]; assign memOut139 = r_mem[139];
    assign memOut140 = r_mem[140]; assign memOut141 = r_mem[141]; assign memOut142 = r_mem[142]; assign memOut143 = r_mem[143];
    assign memOut144 = r_mem[144]; assign memOut145 = r_mem[145]; assign memOut146 = r_mem[146]; assign memOut147 = r_mem[147];
    assign memOut148 = r_mem[148]; assign memOut149 = r_mem[149]; assign memOut150 = r_mem[150]; assign memOut151 = r_mem[151];
    assign memOut152 = r_mem[152]; assign memOut153 = r_mem[153]; assign memOut154 = r_mem[154]; assign memOut155 = r_mem[155];
    assign memOut156 = r_mem[156]; assign memOut157 = r_mem[157]; assign memOut158 = r_mem[158]; assign memOut159 = r_mem[159];
    assign memOut160 = r_mem[160]; assign memOut161 = r_mem[161]; assign memOut162 = r_mem[162]; assign memOut163 = r_mem[163];
    assign memOut164 = r_mem[164]; assign memOut165 = r_mem[165]; assign memOut166 = r_mem[166]; assign memOut167 = r_mem[167];
    assign memOut168 = r_mem[168]; assign memOut169 = r_mem[169]; assign memOut170 = r_mem[170]; assign memOut171 = r_mem[171];
    assign memOut172 = r_mem[172]; assign memOut173 = r_mem[173]; assign memOut174 = r_mem[174]; assign memOut175 = r_mem[175];
    assign memOut176 = r_mem[176]; assign memOut177 = r_mem[177]; assign memOut178 = r_mem[178]; assign memOut179 = r_mem[179];
    assign memOut180 = r_mem[180]; assign memOut181 = r_mem[181]; assign memOut182 = r_mem[182]; assign memOut183 = r_mem[183];
    assign memOut184 = r_mem[184]; assign memOut185 = r_mem[185]; assign memOut186 = r_mem[186]; assign memOut187 = r_mem[187];
    assign memOut188 = r_mem[188]; assign memOut189 = r_mem[189]; assign memOut190 = r_mem[190]; assign memOut191 = r_mem[191];
    assign memOut192 = r_mem[192]; assign memOut193 = r_mem[193]; assign memOut194 = r_mem[194]; assign memOut195 = r_mem[195];
    assign memOut196 = r_mem[196]; assign memOut197 = r_mem[197]; assign memOut198 = r_mem[198]; assign memOut199 = r_mem[199];
    assign memOut200 = r_mem[200]; assign memOut201 = r_mem[201]; assign memOut202 = r_mem[202]; assign memOut203 = r_mem[203];
    assign memOut204 = r_mem[204]; assign memOut205 = r_mem[205]; assign memOut206 = r_mem[206]; assign memOut207 = r_mem[207];
    assign memOut208 = r_mem[208]; assign memOut209 = r_mem[209]; assign memOut210 = r_mem[210]; assign memOut211 = r_mem[211];
    assign memOut212 = r_mem[212]; assign memOut213 = r_mem[213]; assign memOut214 = r_mem[214]; assign memOut215 = r_mem[215];
    assign memOut216 = r_mem[216]; assign memOut217 = r_mem[217]; assign memOut218 = r_mem[218]; assign memOut219 = r_mem[219];
    assign memOut220 = r_mem[220]; assign memOut221 = r_mem[221]; assign memOut222 = r_mem[222]; assign memOut223 = r_mem[223];
    assign memOut224 = r_mem[224]; assign memOut225 = r_mem[225]; assign memOut226 = r_mem[226]; assign memOut227 = r_mem[227];
    assign memOut228 = r_mem[228]; assign memOut229 = r_mem[229]; assign memOut230 = r_mem[230]; assign memOut231 = r_mem[231];
    assign memOut232 = r_mem[232]; assign memOut233 = r_mem[233]; assign memOut234 = r_mem[234]; assign memOut235 = r_mem[235];
    assign memOut236 = r_mem[236]; assign memOut237 = r_mem[237]; assign memOut238 = r_mem[238]; assign memOut239 = r_mem[239];
    assign memOut240 = r_mem[240]; assign memOut241 = r_mem[241]; assign memOut242 = r_mem[242]; assign memOut243 = r_mem[243];
    assign memOut244 = r_mem[244]; assign memOut245 = r_mem[245]; assign memOut246 = r_mem[246]; assign memOut247 = r_mem[247];
    assign memOut248 = r_mem[248]; assign memOut249 = r_mem[249]; assign memOut250 = r_mem[250]; assign memOut251 = r_mem[251];
    assign memOut252 = r_mem[252]; assign memOut253 = r_mem[253]; assign memOut254 = r_mem[254]; assign memOut255 = r_mem[255];
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: word-array reference model checked against RD and every memOutN each cycle,
// plus directed literal checks.
module tb_data_memory;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        MR = 1'b0;
    logic        MW = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WD = '0;
    logic [31:0] RD;
    logic [31:0] mo [256];
    logic [31:0] m [256] = '{default: '0};
    int checks = 0;
    int errors = 0;
    bit en = 1'b1;
    always #5 Clk = ~Clk;
    data_memory dut (
        .Clk(Clk), .Rst(Rst), .MR(MR), .MW(MW), .Addr(Addr), .WD(WD), .RD(RD),
        .memOut0(mo[0]), .memOut1(mo[1]), .memOut2(mo[2]), .memOut3(mo[3]), .memOut4(mo[4]), .memOut5(mo[5]), .memOut6(mo[6]), .memOut7(mo[7]),
        .memOut8(mo[8]), .memOut9(mo[9]), .memOut10(mo[10]), .memOut11(mo[11]), .memOut12(mo[12]), .memOut13(mo[13]), .memOut14(mo[14]), .memOut15(mo[15]),
        .memOut16(mo[16]), .memOut17(mo[17]), .memOut18(mo[18]), .memOut19(mo[19]), .memOut20(mo[20]), .memOut21(mo[21]), .memOut22(mo[22]), .memOut23(mo[23]),
        .memOut24(mo[24]), .memOut25(mo[25]), .memOut26(mo[26]), .memOut27(mo[27]), .memOut28(mo[28]), .memOut29(mo[29]), .memOut30(mo[30]), .memOut31(mo[31]),
        .memOut32(mo[32]), .memOut33(mo[33]), .memOut34(mo[34]), .memOut35(mo[35]), .memOut36(mo[36]), .memOut37(mo[37]), .memOut38(mo[38]), .memOut39(mo[39]),
        .memOut40(mo[40]), .memOut41(mo[41]), .memOut42(mo[42]), .memOut43(mo[43]), .memOut44(mo[44]), .memOut45(mo[45]), .memOut46(mo[46]), .memOut47(mo[47]),
        .memOut48(mo[48]), .memOut49(mo[49]), .memOut50(mo[50]), .memOut51(mo[51]), .memOut52(mo[52]), .memOut53(mo[53]), .memOut54(mo[54]), .memOut55(mo[55]),
        .memOut56(mo[56]), .memOut57(mo[57]), .memOut58(mo[58]), .memOut59(mo[59]), .memOut60(mo[60]), .memOut61(mo[61]), .memOut62(mo[62]), .memOut63(mo[63]),
        .memOut64(mo[64]), .memOut65(mo[65]), .memOut66(mo[66]), .memOut67(mo[67]), .memOut68(mo[68]), .memOut69(mo[69]), .memOut70(mo[70]), .memOut71(mo[71]),
        .memOut72(mo[72]), .memOut73(mo[73]), .memOut74(mo[74]), .memOut75(mo[75]), .memOut76(mo[76]), .memOut77(mo[77]), .memOut78(mo[78]), .memOut79(mo[79]),
        .memOut80(mo[80]), .memOut81(mo[81]), .memOut82(mo[82]), .memOut83(mo[83]), .memOut84(mo[84]), .memOut85(mo[85]), .memOut86(mo[86]), .memOut87(mo[87]),
        .memOut88(mo[88]), .memOut89(mo[89]), .memOut90(mo[90]), .memOut91(mo[91]), .memOut92(mo[92]), .memOut93(mo[93]), .memOut94(mo[94]), .memOut95(mo[95]),
        .memOut96(mo[96]), .memOut97(mo[97]), .memOut98(mo[98]), .memOut99(mo[99]), .memOut100(mo[100]), .memOut101(mo[101]), .memOut102(mo[102]), .memOut103(mo[103]),
        .memOut104(mo[104]), .memOut105(mo[105]), .memOut106(mo[106]), .memOut107(mo[107]), .memOut108(mo[108]), .memOut109(mo[109]), .memOut110(mo[110]), .memOut111(mo[111]),
        .memOut112(mo[112]), .memOut113(mo[113]), .memOut114(mo[114]), .memOut115(mo[115]), .memOut116(mo[116]), .memOut117(mo[117]), .memOut118(mo[118]), .memOut119(mo[119]),
        .memOut120(mo[120]), .memOut121(mo[121]), .memOut122(mo[122]), .memOut123(mo[123]), .memOut124(mo[124]), .memOut125(mo[125]), .memOut126(mo[126]), .memOut127(mo[127]),
        .memOut128(mo[128]), .memOut129(mo[129]), .memOut130(mo[130]), .memOut131(mo[131]), .memOut132(mo[132]), .memOut133(mo[133]), .memOut134(mo[134]), .memOut135(mo[135]),
        .memOut136(mo[136]), .memOut137(mo[137]), .memOut138(mo[138]), .memOut139(mo[139]), .memOut140(mo[140]), .memOut141(mo[141]), .memOut142(mo[142]), .memOut143(mo[143]),
        .memOut144(mo[144]), .memOut145(mo[145]), .memOut146(mo[146]), .memOut147(mo[147]), .memOut148(mo[148]), .memOut149(mo[149]), .memOut150(mo[150]), .memOut151(mo[151]),
        .memOut152(mo[152]), .memOut153(mo[153]), .memOut154(mo[154]), .memOut155(mo[155]), .memOut156(mo[156]), .memOut157(mo[157]), .memOut158(mo[158]), .memOut159(mo[159]),
        .memOut160(mo[160]), .memOut161(mo[161]), .memOut162(mo[162]), .memOut163(mo[163]), .memOut164(mo[164]), .memOut165(mo[165]), .memOut166(mo[166]), .memOut167(mo[167]),
        .memOut168(mo[168]), .memOut169(mo[169]), .memOut170(mo[170]), .memOut171(mo[171]), .memOut172(mo[172]), .memOut173(mo[173]), .memOut174(mo[174]), .memOut175(mo[175]),
        .memOut176(mo[176]), .memOut177(mo[177]), .memOut178(mo[178]), .memOut179(mo[179]), .memOut180(mo[180]), .memOut181(mo[181]), .memOut182(mo[182]), .memOut183(mo[183]),
        .memOut184(mo[184]), .memOut185(mo[185]), .memOut186(mo[186]), .memOut187(mo[187]), .memOut188(mo[188]), .memOut189(mo[189]), .memOut190(mo[190]), .memOut191(mo[191]),
        .memOut192(mo[192]), .memOut193(mo[193]), .memOut194(mo[194]), .memOut195(mo[195]), .memOut196(mo[196]), .memOut197(mo[197]), .memOut198(mo[198]), .memOut199(mo[199]),
        .memOut200(mo[200]), .memOut201(mo[201]), .memOut202(mo[202]), .memOut203(mo[203]), .memOut204(mo[204]), .memOut205(mo[205]), .memOut206(mo[206]), .memOut207(mo[207]),
        .memOut208(mo[208]), .memOut209(mo[209]), .memOut210(mo[210]), .memOut211(mo[211]), .memOut212(mo[212]), .memOut213(mo[213]), .memOut214(mo[214]), .memOut215(mo[215]),
        .memOut216(mo[216]), .memOut217(mo[217]), .memOut218(mo[218]), .memOut219(mo[219]), .memOut220(mo[220]), .memOut221(mo[221]), .memOut222(mo[222]), .memOut223(mo[223]),
        .memOut224(mo[224]), .memOut225(mo[225]), .memOut226(mo[226]), .memOut227(mo[227]), .memOut228(mo[228]), .memOut229(mo[229]), .memOut230(mo[230]), .memOut231(mo[231]),
        .memOut232(mo[232]), .memOut233(mo[233]), .memOut234(mo[234]), .memOut235(mo[235]), .memOut236(mo[236]), .memOut237(mo[237]), .memOut238(mo[238]), .memOut239(mo[239]),
        .memOut240(mo[240]), .memOut241(mo[241]), .memOut242(mo[242]), .memOut243(mo[243]), .memOut244(mo[244]), .memOut245(mo[245]), .memOut246(mo[246]), .memOut247(mo[247]),
        .memOut248(mo[248]), .memOut249(mo[249]), .memOut250(mo[250]), .memOut251(mo[251]), .memOut252(mo[252]), .memOut253(mo[253]), .memOut254(mo[254]), .memOut255(mo[255])
    );
    // Reference model: word index is the byte address divided by 4, modulo 256.
    always @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 256; i++) m[i] <= '0;
        end else if (MW) begin
            m[(Addr / 4) % 256] <= WD;
        end
    end
    always @(negedge Clk) begin
        if (en) begin
            logic [31:0] exp_rd;
            exp_rd = MR ? m[(Addr / 4) % 256] : 32'h0;
            checks++;
            if (RD !== exp_rd) begin
                errors++;
                $display("FAIL rd t=%0t addr=%h got %h want %h", $time, Addr, RD, exp_rd);
            end
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (mo[i] !== m[i]) begin
                    errors++;
                    $display("FAIL memOut%0d t=%0t got %h want %h", i, $time, mo[i], m[i]);
                end
            end
        end
    end
    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic rst, input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] d);
        Rst = rst; MR = mr; MW = mw; Addr = a; WD = d;
        @(posedge Clk);
        #1;
    endtask
    initial begin
        #1;
        lit("power_up_mo0", mo[0], 32'h0);
        lit("power_up_mo255", mo[255], 32'h0);
        drive(0, 0, 1, 32'h10, 32'hDEADBEEF);
        lit("write_mo4", mo[4], 32'hDEADBEEF);
        drive(1, 0, 0, 32'h0, 32'h0);
        lit("reset_mo4", mo[4], 32'h0);
        Rst = 0; MR = 1; Addr = 32'h10; #1;
        lit("reset_rd", RD, 32'h0);
        drive(0, 0, 1, 32'h8, 32'h12345678);
        lit("write_mo2", mo[2], 32'h12345678);
        MR = 1; MW = 0; Addr = 32'h8; #1;
        lit("read_rd", RD, 32'h12345678);
        MR = 0; #1;
        lit("mr0_rd", RD, 32'h0);
        drive(0, 0, 1, 32'hFFFFFC07, 32'hA5A5A5A5);
        lit("alias_mo1", mo[1], 32'hA5A5A5A5);
        MR = 1; MW = 0; Addr = 32'h404; #1;
        lit("alias_rd", RD, 32'hA5A5A5A5);
        drive(0, 0, 1, 32'h3FC, 32'h1);
        lit("top_mo255", mo[255], 32'h1);
        drive(0, 0, 1, 32'hC, 32'h11111111);
        MR = 1; MW = 1; Addr = 32'hC; WD = 32'h22222222; #1;
        lit("rdw_before", RD, 32'h11111111);
        @(posedge Clk); #1;
        lit("rdw_after", RD, 32'h22222222);
        MW = 0; WD = 32'h33333333;
        @(posedge Clk); #1;
        lit("mw0_nochange", RD, 32'h22222222);
        lit("mw0_mo3", mo[3], 32'h22222222);
        drive(0, 0, 1, 32'h20, 32'h77);
        lit("pre_collide_mo8", mo[8], 32'h77);
        drive(1, 0, 1, 32'h20, 32'hFFFFFFFF);
        lit("collide_mo8", mo[8], 32'h0);
        Rst = 0; MW = 0;
        for (int n = 0; n < 5000; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1)) a[31:10] = '0;
            if (n % 3 == 0) a[9:2] = 8'($urandom_range(0, 7));
            drive($urandom_range(0, 199) == 0, 1'($urandom), 1'($urandom), a, $urandom);
        end
        @(negedge Clk);
        en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
